// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port (CPU/DMA) arbiter and single issue stage in front of the data memory
// Define DM_ARB_RR_EN for round-robin arbitration; default is CPU priority with a DMA wait limit.
module dm_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [2:0]  c_wop,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_wop,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_memwrite,
  output logic [2:0]  dm_memwop,
  input  logic [31:0] dm_rdata
);

  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WAIT);
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              last_gnt_q, last_gnt_d;
  logic              iss_we_q, iss_we_d;
  logic              iss_port_q, iss_port_d;
  logic [2:0]        iss_wop_q, iss_wop_d;
  logic [31:0]       iss_addr_q, iss_addr_d;
  logic [31:0]       iss_wdata_q, iss_wdata_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_port_q, rsp_port_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              xfer;

  // Grants are combinational and never both high; nothing is granted while in reset.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (Reset) begin
      if (c_req && d_req) begin
`ifdef DM_ARB_RR_EN
        if (last_gnt_q == PORT_C) d_gnt = 1'b1;
        else                      c_gnt = 1'b1;
`else
        if (wait_q == MAX_W) d_gnt = 1'b1;
        else                 c_gnt = 1'b1;
`endif
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end
  end

  assign xfer = c_gnt | d_gnt;

  always_comb begin
    wait_d = '0;
`ifndef DM_ARB_RR_EN
    if (d_req && !d_gnt) begin
      wait_d = (wait_q == MAX_W) ? wait_q : wait_q + CNT_W'(1);
    end
`endif
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (c_gnt)      last_gnt_d = PORT_C;
    else if (d_gnt) last_gnt_d = PORT_D;
  end

  // Issue FSM: state register
  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Issue FSM: next state (a transfer every cycle keeps it ACTIVE back to back)
  always_comb begin
    state_d = IDLE;
    if (xfer) state_d = ACTIVE;
  end

  // Issue FSM: outputs; the write strobe is gated by reset so a reset cycle never writes.
  always_comb begin
    dm_memwrite = (state_q == ACTIVE) && iss_we_q && Reset;
    dm_addr     = iss_addr_q;
    dm_wdata    = iss_wdata_q;
    dm_memwop   = iss_wop_q;
  end

  always_comb begin
    iss_we_d    = iss_we_q;
    iss_port_d  = iss_port_q;
    iss_wop_d   = iss_wop_q;
    iss_addr_d  = iss_addr_q;
    iss_wdata_d = iss_wdata_q;
    if (c_gnt) begin
      iss_we_d    = c_we;
      iss_port_d  = PORT_C;
      iss_wop_d   = c_wop;
      iss_addr_d  = c_addr;
      iss_wdata_d = c_wdata;
    end else if (d_gnt) begin
      iss_we_d    = d_we;
      iss_port_d  = PORT_D;
      iss_wop_d   = d_wop;
      iss_addr_d  = d_addr;
      iss_wdata_d = d_wdata;
    end
  end

  // Read data is sampled at the end of the access cycle, before the store edge lands.
  always_comb begin
    rsp_vld_d  = (state_q == ACTIVE);
    rsp_port_d = iss_port_q;
    rsp_data_d = (state_q == ACTIVE) ? dm_rdata : rsp_data_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wait_q      <= '0;
      last_gnt_q  <= PORT_C;
      iss_we_q    <= 1'b0;
      iss_port_q  <= PORT_C;
      iss_wop_q   <= '0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_port_q  <= PORT_C;
      rsp_data_q  <= '0;
    end else begin
      wait_q      <= wait_d;
      last_gnt_q  <= last_gnt_d;
      iss_we_q    <= iss_we_d;
      iss_port_q  <= iss_port_d;
      iss_wop_q   <= iss_wop_d;
      iss_addr_q  <= iss_addr_d;
      iss_wdata_q <= iss_wdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_port_q  <= rsp_port_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign c_rvalid = rsp_vld_q && (rsp_port_q == PORT_C);
  assign d_rvalid = rsp_vld_q && (rsp_port_q == PORT_D);
  assign c_rdata  = rsp_data_q;
  assign d_rdata  = rsp_data_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with a word memory model and response scoreboard
module tb_dm_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        c_req, c_we, d_req, d_we;
  logic [2:0]  c_wop, d_wop;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_memwrite;
  logic [2:0]  dm_memwop;

  always #5 Clk = ~Clk;

  dm_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .c_req(c_req), .c_we(c_we), .c_wop(c_wop), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_wop(d_wop), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_memwrite(dm_memwrite),
    .dm_memwop(dm_memwop), .dm_rdata(dm_rdata)
  );

  // Data memory: combinational read, write on the clock edge.
  logic [31:0] dm_mem [16];
  logic [31:0] ref_mem [16];
  assign dm_rdata = dm_mem[dm_addr[5:2]];
  always @(posedge Clk) begin
    if (dm_memwrite) dm_mem[dm_addr[5:2]] <= dm_wdata;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  logic        mon_en = 1'b0;
  logic        s_act  = 1'b0;
  logic        s_port, s_we;
  logic [2:0]  s_wop;
  logic [31:0] s_addr, s_wdata;

  // Monitor: tracks the issued access, builds expected responses, checks rvalid/rdata.
  initial begin
    sb_t e;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp c_rvalid", {31'b0, c_rvalid}, {31'b0, e.port == 1'b0});
          check("rsp d_rvalid", {31'b0, d_rvalid}, {31'b0, e.port == 1'b1});
          if (!e.we) begin
            if (e.port) check("rsp d_rdata", d_rdata, e.data);
            else        check("rsp c_rdata", c_rdata, e.data);
          end
        end else begin
          check("idle c_rvalid", {31'b0, c_rvalid}, 32'd0);
          check("idle d_rvalid", {31'b0, d_rvalid}, 32'd0);
        end
        if (s_act) begin
          check("iss dm_memwrite", {31'b0, dm_memwrite}, {31'b0, s_we & Reset});
          check("iss dm_addr", dm_addr, s_addr);
          check("iss dm_memwop", {29'b0, dm_memwop}, {29'b0, s_wop});
          if (s_we) check("iss dm_wdata", dm_wdata, s_wdata);
          if (Reset) begin
            e.port = s_port;
            e.we   = s_we;
            e.data = ref_mem[s_addr[5:2]];
            if (s_we) ref_mem[s_addr[5:2]] = s_wdata;
            sb.push_back(e);
          end
        end else begin
          check("no-iss dm_memwrite", {31'b0, dm_memwrite}, 32'd0);
        end
        check("single gnt", {31'b0, c_gnt & d_gnt}, 32'd0);
        if (!Reset) begin
          sb.delete();
          s_act = 1'b0;
        end else if (c_req && c_gnt) begin
          s_act = 1'b1; s_port = 1'b0; s_we = c_we; s_wop = c_wop; s_addr = c_addr; s_wdata = c_wdata;
        end else if (d_req && d_gnt) begin
          s_act = 1'b1; s_port = 1'b1; s_we = d_we; s_wop = d_wop; s_addr = d_addr; s_wdata = d_wdata;
        end else begin
          s_act = 1'b0;
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic        c_req, c_we;
    logic [2:0]  c_wop;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        exp_c, exp_d;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic cr, logic cw, logic [2:0] cop, logic [31:0] ca,
                              logic [31:0] cd, logic dr, logic dw, logic [31:0] da,
                              logic [31:0] dd, logic ec, logic ed);
    vec_t v;
    v.name = nm; v.c_req = cr; v.c_we = cw; v.c_wop = cop; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.exp_c = ec; v.exp_d = ed;
    return v;
  endfunction

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_wop = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_wop = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int  ck, dk;
    logic exp_d;
    for (int i = 0; i < 16; i++) begin
      dm_mem[i]  = 32'h0;
      ref_mem[i] = 32'h0;
    end
    vecs.push_back(mk("st c 0x10",   1, 1, 3'b000, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        1, 0));
    vecs.push_back(mk("ld d 0x10",   0, 0, 3'b000, 32'h0,  32'h0,        1, 0, 32'h10, 32'h0,        0, 1));
    vecs.push_back(mk("idle",        0, 0, 3'b000, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0));
    vecs.push_back(mk("both c wins", 1, 0, 3'b000, 32'h10, 32'h0,        1, 1, 32'h20, 32'hCAFE0001, 1, 0));
    vecs.push_back(mk("d store",     0, 0, 3'b000, 32'h0,  32'h0,        1, 1, 32'h20, 32'hCAFE0001, 0, 1));
    vecs.push_back(mk("c sh",        1, 1, 3'b001, 32'h14, 32'h0000A5A5, 0, 0, 32'h0,  32'h0,        1, 0));
    vecs.push_back(mk("ld d 0x20",   0, 0, 3'b000, 32'h0,  32'h0,        1, 0, 32'h20, 32'h0,        0, 1));
    vecs.push_back(mk("ld c 0x14",   1, 0, 3'b000, 32'h14, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0));
    vecs.push_back(mk("c sb",        1, 1, 3'b010, 32'h18, 32'h00000077, 1, 0, 32'h14, 32'h0,        1, 0));
    vecs.push_back(mk("ld d 0x14",   0, 0, 3'b000, 32'h0,  32'h0,        1, 0, 32'h14, 32'h0,        0, 1));
    vecs.push_back(mk("idle",        0, 0, 3'b000, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0));
    vecs.push_back(mk("idle",        0, 0, 3'b000, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0));

    // Reset held for two edges while the CPU asks for a store.
    idle_inputs();
    Reset = 0; c_req = 1; c_we = 1;
    next_cycle();
    @(negedge Clk);
    check("rst c_gnt", {31'b0, c_gnt}, 32'd0);
    check("rst d_gnt", {31'b0, d_gnt}, 32'd0);
    check("rst dm_memwrite", {31'b0, dm_memwrite}, 32'd0);
    check("rst c_rvalid", {31'b0, c_rvalid}, 32'd0);
    check("rst d_rvalid", {31'b0, d_rvalid}, 32'd0);
    check("rst dm_addr", dm_addr, 32'h0);
    next_cycle();
    Reset = 1;
    idle_inputs();
    mon_en = 1;

    // Continuous contention for 15 cycles.
    ck = 0; dk = 0;
    for (int i = 0; i < 15; i++) begin
      c_req = 1; c_we = 1; c_wop = 0; c_addr = 32'(4 * (ck % 4)); c_wdata = 32'h1000 + 32'(ck);
      d_req = 1; d_we = 0; d_wop = 0; d_addr = 32'(4 * (dk % 4));
      @(negedge Clk);
`ifdef DM_ARB_RR_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = (i % 5 == 4);
`endif
      check($sformatf("contend c_gnt[%0d]", i), {31'b0, c_gnt}, {31'b0, !exp_d});
      check($sformatf("contend d_gnt[%0d]", i), {31'b0, d_gnt}, {31'b0, exp_d});
      if (c_gnt) ck++;
      if (d_gnt) dk++;
      next_cycle();
    end
    idle_inputs();
    repeat (3) next_cycle();

    foreach (vecs[i]) begin
      c_req = vecs[i].c_req; c_we = vecs[i].c_we; c_wop = vecs[i].c_wop;
      c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_wop = 3'b000;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      @(negedge Clk);
      check({vecs[i].name, " c_gnt"}, {31'b0, c_gnt}, {31'b0, vecs[i].exp_c});
      check({vecs[i].name, " d_gnt"}, {31'b0, d_gnt}, {31'b0, vecs[i].exp_d});
      next_cycle();
    end

    // Reset lands in the access cycle of a store: no write, no response.
    c_req = 1; c_we = 1; c_wop = 0; c_addr = 32'h24; c_wdata = 32'h12345678;
    @(negedge Clk);
    check("t5 c_gnt", {31'b0, c_gnt}, 32'd1);
    next_cycle();
    idle_inputs();
    Reset = 0;
    @(negedge Clk);
    check("t5 dm_memwrite", {31'b0, dm_memwrite}, 32'd0);
    next_cycle();
    Reset = 1;
    repeat (3) next_cycle();
    check("t5 word unchanged", dm_mem[9], 32'h0);
    c_req = 1; c_we = 0; c_addr = 32'h24;
    @(negedge Clk);
    check("t5 reload c_gnt", {31'b0, c_gnt}, 32'd1);
    next_cycle();
    idle_inputs();
    repeat (4) next_cycle();
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
